// File: rtl/input_vc_unit.sv
// Input virtual-channel unit: flit FIFO, head routing / VC request, switch request
// gated by downstream credits, registered flit departure and upstream credit return.
module input_vc_unit #(
    parameter int VID_BITS = 6,
    parameter int PORTS    = 5,
    parameter int CHANNELS = 12,
    parameter int FLIT_W   = 32,
    parameter int DEPTH    = 4,
    parameter int CREDITS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [FLIT_W-1:0]        in_flit,
    input  logic                     in_head,
    input  logic                     in_tail,
    output logic                     credit_out,
    output logic                     va_req,
    output logic [$clog2(PORTS)-1:0] va_port,
    input  logic                     va_gnt,
    input  logic [VID_BITS-1:0]      va_ovid,
    output logic                     sa_req,
    output logic [VID_BITS-1:0]      g_ovid,
    input  logic                     sa_gnt,
    input  logic                     credit_in,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_flit,
    output logic                     out_tail,
    output logic                     vc_release,
    output logic                     ovf_err
);
    localparam int PW = $clog2(PORTS);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int NUM_VCS = PORTS * CHANNELS;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef struct packed {
        logic              tail;
        logic              head;
        logic [FLIT_W-1:0] flit;
    } entry_t;

    typedef enum logic [1:0] {IDLE, VA, ACTIVE} state_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] cnt;
    state_t        state;
    entry_t        front;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;

    assign front = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Requests are masked by rst so nothing reaches the allocators while resetting.
    assign va_req = (state == VA) && !rst;
    assign sa_req = (state == ACTIVE) && !empty && (cnt != '0) && !rst;
    assign pop    = sa_req && sa_gnt;
    assign push   = in_valid && (!full || pop);

    // NOTE: the buffer array is not reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{tail: in_tail, head: in_head, flit: in_flit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            cnt        <= '0;
            state      <= IDLE;
            va_port    <= '0;
            g_ovid     <= '0;
            out_valid  <= 1'b0;
            out_flit   <= '0;
            out_tail   <= 1'b0;
            vc_release <= 1'b0;
            credit_out <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);

            out_valid  <= pop;
            credit_out <= pop;
            vc_release <= pop && front.tail;
            if (pop) begin
                out_flit <= front.flit;
                out_tail <= front.tail;
            end

            if (in_valid && full && !pop) ovf_err <= 1'b1;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (front.head) begin
                            state   <= VA;
                            va_port <= front.flit[PW-1:0];
                        end else begin
                            // A body flit with no packet open is stuck here by design.
                            ovf_err <= 1'b1;
                        end
                    end
                end
                VA: begin
                    if (va_gnt) begin
                        g_ovid <= va_ovid;
                        cnt    <= CRED_MAX;
                        state  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (credit_in && !pop && cnt != CRED_MAX) begin
                        cnt <= cnt + CW'(1);
                    end else if (pop && !credit_in) begin
                        cnt <= cnt - CW'(1);
                    end
                    if (pop && front.tail) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && va_req && va_gnt) begin
            assert (int'(va_ovid) < NUM_VCS);
        end
    end
endmodule

// File: tb/tb_input_vc_unit.sv
// Bench for input_vc_unit: packet-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized credit-obeying traffic.
module tb_input_vc_unit;
    localparam int VID_BITS = 6;
    localparam int PORTS    = 5;
    localparam int CHANNELS = 12;
    localparam int FLIT_W   = 32;
    localparam int DEPTH    = 4;
    localparam int CREDITS  = 4;
    localparam int PW       = $clog2(PORTS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid, in_head, in_tail, va_gnt, sa_gnt, credit_in;
    logic [FLIT_W-1:0]   in_flit;
    logic [VID_BITS-1:0] va_ovid;
    logic credit_out, va_req, sa_req, out_valid, out_tail, vc_release, ovf_err;
    logic [PW-1:0]       va_port;
    logic [VID_BITS-1:0] g_ovid;
    logic [FLIT_W-1:0]   out_flit;

    always #5 clk = ~clk;

    input_vc_unit #(
        .VID_BITS(VID_BITS), .PORTS(PORTS), .CHANNELS(CHANNELS),
        .FLIT_W(FLIT_W), .DEPTH(DEPTH), .CREDITS(CREDITS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_flit(in_flit), .in_head(in_head), .in_tail(in_tail),
        .credit_out(credit_out), .va_req(va_req), .va_port(va_port),
        .va_gnt(va_gnt), .va_ovid(va_ovid), .sa_req(sa_req), .g_ovid(g_ovid),
        .sa_gnt(sa_gnt), .credit_in(credit_in), .out_valid(out_valid),
        .out_flit(out_flit), .out_tail(out_tail), .vc_release(vc_release),
        .ovf_err(ovf_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic              head;
        logic              tail;
        logic [FLIT_W-1:0] data;
    } flit_t;

    typedef enum {WAIT_HEAD, WAIT_VC, SENDING} phase_t;

    flit_t  q[$];
    phase_t ph = WAIT_HEAD;
    int     m_cred = 0;
    int     m_port = 0;
    int     m_ovid = 0;
    bit     m_ov = 0, m_cr = 0, m_rel = 0, m_tail = 0, m_ovf = 0;
    logic [FLIT_W-1:0] m_flit = '0;
    bit     started = 0;

    function automatic bit m_sa_req();
        return ph == SENDING && q.size() > 0 && m_cred > 0 && !rst;
    endfunction

    always @(posedge clk) begin : model
        bit pop;
        flit_t f;
        int sz;
        if (rst) begin
            q.delete();
            ph = WAIT_HEAD; m_cred = 0; m_port = 0; m_ovid = 0;
            m_ov = 0; m_cr = 0; m_rel = 0; m_tail = 0; m_ovf = 0; m_flit = '0;
            started = 1;
        end else begin
            pop = sa_gnt && m_sa_req();
            sz  = q.size();
            m_ov = pop; m_cr = pop; m_rel = 0;
            if (pop) begin
                f = q.pop_front();
                m_flit = f.data; m_tail = f.tail; m_rel = f.tail;
            end
            case (ph)
                WAIT_HEAD: if (sz > 0) begin
                    if (q[0].head) begin
                        ph = WAIT_VC;
                        m_port = int'(q[0].data[PW-1:0]);
                    end else m_ovf = 1;
                end
                WAIT_VC: if (va_gnt) begin
                    ph = SENDING; m_ovid = int'(va_ovid); m_cred = CREDITS;
                end
                default: begin
                    m_cred = m_cred + int'(credit_in) - int'(pop);
                    if (m_cred > CREDITS) m_cred = CREDITS;
                    if (pop && f.tail) ph = WAIT_HEAD;
                end
            endcase
            if (in_valid) begin
                if (sz == DEPTH && !pop) m_ovf = 1;
                else q.push_back('{head: in_head, tail: in_tail, data: in_flit});
            end
        end
    end

    int cnt_out = 0, cnt_cr = 0, cnt_rel = 0;

    always @(negedge clk) begin : compare
        if (started) begin
            check("va_req",     va_req,     ph == WAIT_VC && !rst);
            check("sa_req",     sa_req,     m_sa_req());
            check("va_port",    va_port,    m_port);
            check("g_ovid",     g_ovid,     m_ovid);
            check("out_valid",  out_valid,  m_ov);
            check("credit_out", credit_out, m_cr);
            check("vc_release", vc_release, m_rel);
            check("out_tail",   out_tail,   m_tail);
            check("out_flit",   out_flit,   m_flit);
            check("ovf_err",    ovf_err,    m_ovf);
            cnt_out += int'(out_valid);
            cnt_cr  += int'(credit_out);
            cnt_rel += int'(vc_release);
        end
    end

    // ---------------- stimulus helpers ----------------
    bit    auto_en = 0;
    flit_t txq[$];
    int    up_cred = DEPTH;

    always @(posedge clk) begin : auto_drive
        flit_t f;
        #1;
        if (auto_en) begin
            up_cred += int'(credit_out);
            in_valid = 0; in_head = 0; in_tail = 0;
            if (txq.size() > 0 && up_cred > 0 && $urandom_range(3) != 0) begin
                f = txq.pop_front();
                in_valid = 1; in_head = f.head; in_tail = f.tail; in_flit = f.data;
                up_cred--;
            end
            va_gnt    = $urandom_range(1);
            va_ovid   = VID_BITS'($urandom_range(PORTS * CHANNELS - 1));
            sa_gnt    = $urandom_range(1);
            credit_in = ($urandom_range(2) == 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_flit = '0; in_head = 0; in_tail = 0;
        va_gnt = 0; va_ovid = '0; sa_gnt = 0; credit_in = 0;
    endtask

    task automatic reset_dut();
        rst = 1; idle_inputs();
        step(); step();
        rst = 0;
        cnt_out = 0; cnt_cr = 0; cnt_rel = 0;
    endtask

    task automatic put(input logic [FLIT_W-1:0] d, input logic h, input logic t);
        in_valid = 1; in_flit = d; in_head = h; in_tail = t;
    endtask

    task automatic run_auto(input int limit, input string name);
        int c;
        up_cred = DEPTH;
        auto_en = 1;
        c = 0;
        while (!(txq.size() == 0 && q.size() == 0 && ph == WAIT_HEAD && up_cred == DEPTH)
               && c < limit) begin
            step(); c++;
        end
        check(name, c < limit, 1);
        auto_en = 0;
        step(); idle_inputs(); step();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int total;
        idle_inputs();
        reset_dut();
        @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_ovf", ovf_err, 0);
        check("reset_g_ovid", g_ovid, 0);
        check("post_rst_va_req", va_req, 0);

        // 1: single head+tail flit
        put(32'hA5A5_0002, 1, 1); step();
        idle_inputs(); step();
        va_gnt = 1; va_ovid = 17;
        @(negedge clk);
        check("t1_va_req", va_req, 1);
        check("t1_va_port", va_port, 2);
        step(); va_gnt = 0; sa_gnt = 1;
        @(negedge clk);
        check("t1_sa_req", sa_req, 1);
        check("t1_g_ovid", g_ovid, 17);
        step(); sa_gnt = 0;
        @(negedge clk);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_tail", out_tail, 1);
        check("t1_vc_release", vc_release, 1);
        check("t1_credit_out", credit_out, 1);
        check("t1_out_flit", out_flit, 32'hA5A5_0002);
        step(); step();
        @(negedge clk);
        check("t1_back_idle", va_req, 0);

        // 2: five-flit packet through a 4-deep buffer, upstream obeys credits
        reset_dut();
        for (int i = 0; i < 5; i++)
            txq.push_back('{head: i == 0, tail: i == 4, data: 32'h2000_0003 + 32'(i << 8)});
        run_auto(500, "t2_drain_timeout");
        check("t2_out_count", cnt_out, 5);
        check("t2_credit_out_count", cnt_cr, 5);
        check("t2_release_count", cnt_rel, 1);

        // 3: credits exhausted after 4 flits, 6-flit packet
        reset_dut();
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 14; c++) begin
                idle_inputs();
                sa_gnt = 1; va_gnt = 1; va_ovid = 5;
                if (sent < 6 && (q.size() < DEPTH || m_sa_req())) begin
                    put(32'h3000_0001 + 32'(sent << 8), sent == 0, sent == 5);
                    sent++;
                end
                step();
            end
        end
        idle_inputs();
        @(negedge clk);
        check("t3_sa_req_blocked", sa_req, 0);
        check("t3_fifo_nonempty", q.size(), 2);
        step();
        check("t3_four_out", cnt_out, 4);
        credit_in = 1;
        step();
        credit_in = 1; sa_gnt = 1;
        @(negedge clk);
        check("t3_sa_req_after_credit", sa_req, 1);
        // 4: credit_in with a granted pop at cnt=1
        step();
        credit_in = 0; sa_gnt = 1;
        @(negedge clk);
        check("t4_sa_req_held", sa_req, 1);
        step(); idle_inputs(); step();
        check("t3_six_out", cnt_out, 6);
        check("t3_one_release", cnt_rel, 1);

        // 5: overflow drops the flit and sticks
        reset_dut();
        put(32'h5000_0000, 1, 0); step();
        put(32'h5000_0101, 0, 0); step();
        put(32'h5000_0202, 0, 0); step();
        put(32'h5000_0303, 0, 1); step();
        put(32'hDEAD_0001, 1, 1); step();
        idle_inputs();
        @(negedge clk);
        check("t5_ovf_set", ovf_err, 1);
        step(); step(); step();
        @(negedge clk);
        check("t5_ovf_sticky", ovf_err, 1);
        va_gnt = 1; va_ovid = 9; step();
        va_gnt = 0; sa_gnt = 1;
        for (int c = 0; c < 8; c++) step();
        idle_inputs(); step(); step();
        check("t5_four_out", cnt_out, 4);
        @(negedge clk);
        check("t5_ovf_still", ovf_err, 1);
        check("t5_dropped_absent", va_req, 0);

        // 6: reset mid-packet with 3 flits buffered
        reset_dut();
        va_gnt = 1; va_ovid = 33;
        put(32'h6000_0004, 1, 0); step();
        put(32'h6000_0105, 0, 0); step();
        put(32'h6000_0206, 0, 0); step();
        in_valid = 0; in_head = 0; step();
        va_gnt = 0; rst = 1; step();
        rst = 0; cnt_out = 0; cnt_rel = 0;
        @(negedge clk);
        check("t6_g_ovid_zero", g_ovid, 0);
        check("t6_sa_req_zero", sa_req, 0);
        check("t6_va_req_zero", va_req, 0);
        check("t6_out_valid_zero", out_valid, 0);
        step();
        put(32'h6100_0003, 1, 1); step();
        idle_inputs(); va_gnt = 1; va_ovid = 40; sa_gnt = 1;
        for (int c = 0; c < 6; c++) step();
        idle_inputs(); step(); step();
        check("t6_new_pkt_out", cnt_out, 1);
        check("t6_new_pkt_release", cnt_rel, 1);
        check("t6_new_pkt_port", va_port, 3);

        // randomized credit-obeying traffic
        reset_dut();
        total = 0;
        for (int p = 0; p < 40; p++) begin
            int len;
            logic [FLIT_W-1:0] d;
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                d = $urandom();
                if (i == 0) d[PW-1:0] = PW'($urandom_range(PORTS - 1));
                txq.push_back('{head: i == 0, tail: i == len - 1, data: d});
            end
            total += len;
        end
        run_auto(20000, "rand_drain_timeout");
        check("rand_out_count", cnt_out, total);
        check("rand_release_count", cnt_rel, 40);
        check("rand_no_ovf", ovf_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
